// File: rtl/accum_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accum_pkg : shared types and the saturating/wrapping add helper      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package accum_pkg;

  typedef enum logic {ACC_WRAP = 1'b0, ACC_SAT = 1'b1} acc_mode_e;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

  // Result is {ovf, new_sum}; sums are carried in 64 bits so one helper
  // serves every SUM_W below 64.
  function automatic logic [64:0] acc_add(input logic [63:0] sum,
                                          input logic [63:0] data,
                                          input int          sum_w,
                                          input acc_mode_e   mode);
    logic [64:0] full;
    logic [63:0] maxv;
    logic        ovf;
    logic [64:0] res;
    maxv = (64'd1 << sum_w) - 64'd1;
    full = {1'b0, sum} + {1'b0, data};
    ovf  = (full > {1'b0, maxv});
    if (!ovf)
      res = {1'b0, full[63:0]};
    else if (mode == ACC_SAT)
      res = {1'b1, maxv};
    else
      res = {1'b1, full[63:0] & maxv};
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accum_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accum_mc_if : sample input and result output handshake bundle        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface accum_mc_if #(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16,
  parameter int CNT_W  = 16,
  parameter int CH_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] data_in;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic              bad_ch;

  modport slave (
    input  in_valid, in_ch, data_in, in_last, out_ready,
    output in_ready, out_valid, out_ch, sum, out_count, out_ovf, bad_ch
  );

  modport master (
    output in_valid, in_ch, data_in, in_last, out_ready,
    input  in_ready, out_valid, out_ch, sum, out_count, out_ovf, bad_ch
  );
endinterface
`default_nettype wire

// File: rtl/accum_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accum_lane : one channel's running sum, sample count and sticky ovf  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module accum_lane
  import accum_pkg::*;
#(
  parameter int        DATA_W = 8,
  parameter int        SUM_W  = 16,
  parameter int        CNT_W  = 16,
  parameter acc_mode_e MODE   = ACC_WRAP
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              add_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [SUM_W-1:0]  sum_d_o,
  output logic [CNT_W-1:0]  count_d_o,
  output logic              ovf_d_o
);

  logic [SUM_W-1:0]  sum_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic [64:0]       w_add;
  logic [63-SUM_W:0] w_unused_hi;

  always_comb w_add = acc_add(64'(sum_q), 64'(data_i), SUM_W, MODE);

  assign sum_d_o     = w_add[SUM_W-1:0];
  assign w_unused_hi = w_add[63:SUM_W];
  assign ovf_d_o     = ovf_q | w_add[64];
  assign count_d_o   = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  // A last beat hands its updated values to the output slot and restarts the frame.
  always_ff @(posedge clock) begin
    if (rst) begin
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (add_i) begin
      if (last_i) begin
        sum_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        sum_q   <= sum_d_o;
        count_q <= count_d_o;
        ovf_q   <= ovf_d_o;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/accum_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accum_mc : multi-channel streaming accumulator with result slot      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module accum_mc
  import accum_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SUM_W    = 16,
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int SAT_MODE = 0,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic       clock,
  input  logic       rst,
  accum_mc_if.slave  bus
);

  localparam acc_mode_e MODE = (SAT_MODE != 0) ? ACC_SAT : ACC_WRAP;

  slot_state_e      slot_q, slot_d;
  logic             w_load;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_ch_ok;
  logic             w_take_last;
  logic             w_xfer;

  logic [SUM_W-1:0] w_lane_sum [NUM_CH];
  logic [CNT_W-1:0] w_lane_cnt [NUM_CH];
  logic             w_lane_ovf [NUM_CH];
  logic [SUM_W-1:0] w_sel_sum;
  logic [CNT_W-1:0] w_sel_cnt;
  logic             w_sel_ovf;

  logic [CH_W-1:0]  out_ch_q;
  logic [SUM_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_ovf_q;
  logic             bad_q;

  assign w_in_ready  = (slot_q == SLOT_EMPTY) || bus.out_ready;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_ch_ok     = int'(bus.in_ch) < NUM_CH;
  assign w_take_last = w_accept && w_ch_ok && bus.in_last;
  assign w_xfer      = (slot_q == SLOT_FULL) && bus.out_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    accum_lane #(
      .DATA_W (DATA_W),
      .SUM_W  (SUM_W),
      .CNT_W  (CNT_W),
      .MODE   (MODE)
    ) u_lane (
      .clock     (clock),
      .rst       (rst),
      .add_i     (w_accept && w_ch_ok && (bus.in_ch == CH_W'(i))),
      .last_i    (bus.in_last),
      .data_i    (bus.data_in),
      .sum_d_o   (w_lane_sum[i]),
      .count_d_o (w_lane_cnt[i]),
      .ovf_d_o   (w_lane_ovf[i])
    );
  end

  // Compare-based select keeps out-of-range channel codes from indexing past the lanes.
  always_comb begin
    w_sel_sum = '0;
    w_sel_cnt = '0;
    w_sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.in_ch == CH_W'(i)) begin
        w_sel_sum = w_lane_sum[i];
        w_sel_cnt = w_lane_cnt[i];
        w_sel_ovf = w_lane_ovf[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) slot_q <= SLOT_EMPTY;
    else     slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    w_load = 1'b0;
    case (slot_q)
      SLOT_EMPTY: begin
        if (w_take_last) begin
          slot_d = SLOT_FULL;
          w_load = 1'b1;
        end
      end
      SLOT_FULL: begin
        if (w_xfer) begin
          if (w_take_last) begin
            slot_d = SLOT_FULL;
            w_load = 1'b1;
          end else begin
            slot_d = SLOT_EMPTY;
          end
        end
      end
      default: slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      out_ch_q  <= '0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      bad_q <= w_accept && !w_ch_ok;
      if (w_load) begin
        out_ch_q  <= bus.in_ch;
        out_sum_q <= w_sel_sum;
        out_cnt_q <= w_sel_cnt;
        out_ovf_q <= w_sel_ovf;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (slot_q == SLOT_FULL);
  assign bus.out_ch    = out_ch_q;
  assign bus.sum       = out_sum_q;
  assign bus.out_count = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.bad_ch    = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_accum_mc : three configurations (16b wrap 4ch, 10b wrap 3ch,      |
// | 10b saturate 3ch 3b count) against a scoreboarded frame-sum model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_accum_mc;

  typedef struct {
    int     ch;
    longint sum;
    int     cnt;
    bit     ovf;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  logic       vld [3];
  logic       lst [3];
  logic       ordy [3];
  logic [7:0] chv [3];
  logic [7:0] din [3];

  logic        o_rdy [3];
  logic        o_valid [3];
  logic [1:0]  o_ch [3];
  logic [15:0] o_sum [3];
  logic [15:0] o_cnt [3];
  logic        o_ovf [3];
  logic        o_bad [3];

  logic rdy_s [3]    = '{1'b0, 1'b0, 1'b0};
  logic exp_bad [3]  = '{1'b0, 1'b0, 1'b0};
  logic exp_ov [3]   = '{1'b0, 1'b0, 1'b0};
  logic rst_seen [3] = '{1'b0, 1'b0, 1'b0};
  logic to_flag [3]  = '{1'b0, 1'b0, 1'b0};

  exp_t   exp_q [3][$];
  longint tot [3][4];
  int     cnt [3][4];

  logic        held [3] = '{1'b0, 1'b0, 1'b0};
  logic [1:0]  h_ch [3];
  logic [15:0] h_sum [3];
  logic [15:0] h_cnt [3];
  logic        h_ovf [3];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int nch(int k);
    return (k == 0) ? 4 : 3;
  endfunction
  function automatic longint smax(int k);
    return (k == 0) ? 64'd65535 : 64'd1023;
  endfunction
  function automatic int cmax(int k);
    return (k == 2) ? 7 : 65535;
  endfunction
  function automatic bit sat(int k);
    return (k == 2);
  endfunction

  task automatic check(string name, int k, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL cfg%0d %s: actual=%0d required=%0d", k, name, act, req);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_cfg
    localparam int NCH = (k == 0) ? 4 : 3;
    localparam int SW  = (k == 0) ? 16 : 10;
    localparam int CW  = (k == 2) ? 3 : 16;
    localparam int SAT = (k == 2) ? 1 : 0;

    accum_mc_if #(.DATA_W(8), .SUM_W(SW), .CNT_W(CW), .CH_W(2)) u_if ();

    accum_mc #(
      .DATA_W   (8),
      .SUM_W    (SW),
      .NUM_CH   (NCH),
      .CNT_W    (CW),
      .SAT_MODE (SAT)
    ) u_dut (
      .clock (clock),
      .rst   (rst),
      .bus   (u_if)
    );

    assign u_if.in_valid  = vld[k];
    assign u_if.in_ch     = chv[k][1:0];
    assign u_if.data_in   = din[k];
    assign u_if.in_last   = lst[k];
    assign u_if.out_ready = ordy[k];
    assign o_rdy[k]       = u_if.in_ready;
    assign o_valid[k]     = u_if.out_valid;
    assign o_ch[k]        = u_if.out_ch;
    assign o_sum[k]       = 16'(u_if.sum);
    assign o_cnt[k]       = 16'(u_if.out_count);
    assign o_ovf[k]       = u_if.out_ovf;
    assign o_bad[k]       = u_if.bad_ch;
  end

  // Reference model: true running total per channel, result derived from it.
  always @(posedge clock) begin : b_model
    exp_t e;
    int   c;
    for (int k = 0; k < 3; k++) begin
      rst_seen[k] = rst;
      exp_bad[k]  = 1'b0;
      exp_ov[k]   = 1'b0;
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          tot[k][i] = 0;
          cnt[k][i] = 0;
        end
        exp_q[k].delete();
      end else if (vld[k] && rdy_s[k]) begin
        c = int'(chv[k]);
        if (c >= nch(k)) begin
          exp_bad[k] = 1'b1;
        end else begin
          tot[k][c] += longint'(din[k]);
          if (cnt[k][c] < cmax(k)) cnt[k][c]++;
          if (lst[k]) begin
            e.ch  = c;
            e.cnt = cnt[k][c];
            e.ovf = (tot[k][c] > smax(k));
            if (!e.ovf)     e.sum = tot[k][c];
            else if (sat(k)) e.sum = smax(k);
            else            e.sum = tot[k][c] % (smax(k) + 1);
            exp_q[k].push_back(e);
            tot[k][c] = 0;
            cnt[k][c] = 0;
            exp_ov[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clock) begin : b_mon
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      rdy_s[k] = o_rdy[k];
      if (rst_seen[k]) begin
        check("rst_out_valid", k, 64'(o_valid[k]), 64'd0);
        check("rst_out_ch",    k, 64'(o_ch[k]),    64'd0);
        check("rst_sum",       k, 64'(o_sum[k]),   64'd0);
        check("rst_out_count", k, 64'(o_cnt[k]),   64'd0);
        check("rst_out_ovf",   k, 64'(o_ovf[k]),   64'd0);
        check("rst_bad_ch",    k, 64'(o_bad[k]),   64'd0);
        held[k] = 1'b0;
      end else begin
        check("in_ready", k, 64'(o_rdy[k]), 64'(!o_valid[k] || ordy[k]));
        check("bad_ch", k, 64'(o_bad[k]), 64'(exp_bad[k]));
        check("accept_timeout", k, 64'(to_flag[k]), 64'd0);
        if (exp_ov[k]) check("out_valid_after_last", k, 64'(o_valid[k]), 64'd1);
        if (o_valid[k] === 1'b1) begin
          if (held[k]) begin
            check("hold_out_ch",    k, 64'(o_ch[k]),  64'(h_ch[k]));
            check("hold_sum",       k, 64'(o_sum[k]), 64'(h_sum[k]));
            check("hold_out_count", k, 64'(o_cnt[k]), 64'(h_cnt[k]));
            check("hold_out_ovf",   k, 64'(o_ovf[k]), 64'(h_ovf[k]));
          end
          if (ordy[k]) begin
            check("result_expected", k, 64'(exp_q[k].size() > 0), 64'd1);
            if (exp_q[k].size() > 0) begin
              e = exp_q[k].pop_front();
              check("out_ch",    k, 64'(o_ch[k]),  64'(e.ch));
              check("sum",       k, 64'(o_sum[k]), 64'(e.sum));
              check("out_count", k, 64'(o_cnt[k]), 64'(e.cnt));
              check("out_ovf",   k, 64'(o_ovf[k]), 64'(e.ovf));
            end
            held[k] = 1'b0;
          end else begin
            held[k]  = 1'b1;
            h_ch[k]  = o_ch[k];
            h_sum[k] = o_sum[k];
            h_cnt[k] = o_cnt[k];
            h_ovf[k] = o_ovf[k];
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic beat(int k, int c, int d, bit l);
    int n = 0;
    vld[k] = 1'b1;
    chv[k] = 8'(c);
    din[k] = 8'(d);
    lst[k] = l;
    forever begin
      @(posedge clock);
      if (rdy_s[k]) break;
      n++;
      if (n > 200) begin
        to_flag[k] = 1'b1;
        break;
      end
    end
    #1;
    vld[k] = 1'b0;
    lst[k] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rand_phase(int k, int n);
    bit on = 1'b1;
    fork
      begin
        repeat (n) beat(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                        $urandom_range(0, 3) == 0);
        on = 1'b0;
      end
      while (on) begin
        @(posedge clock);
        #1;
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
    join
    ordy[k] = 1'b1;
    idle(4);
  endtask

  initial begin : b_watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : b_main
    for (int k = 0; k < 3; k++) begin
      vld[k]  = 1'b0;
      lst[k]  = 1'b0;
      ordy[k] = 1'b1;
      chv[k]  = 8'd0;
      din[k]  = 8'd0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;

    fork
      begin
        beat(0, 0, 10, 0); beat(0, 0, 20, 0); beat(0, 0, 30, 1);
        idle(2);
        beat(0, 0, 5, 1);
        idle(2);
        beat(0, 0, 1, 0); beat(0, 2, 100, 0); beat(0, 0, 2, 1); beat(0, 2, 50, 1);
        idle(3);
        ordy[0] = 1'b0;
        beat(0, 1, 11, 1);
        fork
          beat(0, 2, 22, 1);
          begin
            repeat (6) @(posedge clock);
            #1;
            ordy[0] = 1'b1;
          end
        join
        idle(3);
      end
      begin
        repeat (4) beat(1, 1, 255, 0);
        beat(1, 1, 255, 1);
        idle(2);
        beat(1, 3, 40, 0);
        beat(1, 0, 4, 1);
        idle(3);
      end
      begin
        repeat (4) beat(2, 1, 255, 0);
        beat(2, 1, 255, 1);
        idle(2);
        repeat (9) beat(2, 2, 1, 0);
        beat(2, 2, 1, 1);
        idle(2);
        beat(2, 3, 99, 1);
        beat(2, 0, 1023 & 255, 1);
        idle(3);
      end
    join

    fork
      rand_phase(0, 150);
      rand_phase(1, 150);
      rand_phase(2, 150);
    join
    idle(5);

    beat(0, 3, 7, 0);
    beat(0, 3, 8, 0);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    beat(0, 3, 9, 1);
    idle(5);

    for (int k = 0; k < 3; k++) check("results_drained", k, 64'(exp_q[k].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accum_mc.md
Name: accum_mc

Overview:
Multi-channel streaming accumulator. It is the parametrised successor to the single-channel 8-bit-in, 16-bit-sum accumulator.
- Samples arrive tagged with a channel index and are summed per channel.
- A sample flagged "last" closes that channel's frame. The block then emits the frame sum, sample count and overflow flag over a valid/ready output and clears the channel.
- Overflow is handled by wrap or saturate mode, chosen at elaboration.

Parameters:
DATA_W, 8, width of unsigned input sample
SUM_W, 16, width of each channel accumulator and output sum (SUM_W >= DATA_W)
NUM_CH, 4, number of channels (1..256)
CNT_W, 16, width of per-channel sample counter
SAT_MODE, 0, 0 = wrap modulo 2^SUM_W, 1 = clamp at 2^SUM_W-1
CH_W, $clog2(NUM_CH) (min 1), derived channel index width

Ports:
clock  in  1  sole clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_ch  in  CH_W  channel of sample
data_in  in  DATA_W  unsigned sample
in_last  in  1  sample closes the frame of in_ch
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_ch  out  CH_W  channel of result
sum  out  SUM_W  frame sum
out_count  out  CNT_W  samples in frame (including last)
out_ovf  out  1  overflow/clamp occurred during frame
bad_ch  out  1  one-cycle pulse: accepted sample had in_ch >= NUM_CH

Behaviour:
- Reset (rst=1 at posedge): all channel sums, counts and sticky ovf go to 0; out_valid, out_ch, sum, out_count, out_ovf and bad_ch go to 0. Reset mid-frame discards partial sums. Reset has priority over every other event.
- Handshake: beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational, no dependence on in_valid). Result transfers when out_valid && out_ready.
- Output slot FSM, two states:
  - EMPTY -> FULL on an accepted last beat.
  - FULL -> EMPTY on transfer with no new last beat.
  - FULL -> FULL when transfer and an accepted last beat occur in the same cycle. The slot is reloaded and there is no bubble.
- Output fields are held stable while out_valid && !out_ready.
- Non-last beat on channel c, next edge:
  - sum[c] <= sum[c] + data_in. Width is SUM_W+1 internally; carry-out means overflow.
  - Wrap mode stores the low SUM_W bits. Saturate mode stores 2^SUM_W-1 on overflow.
  - ovf[c] set sticky on overflow.
  - count[c] increments and saturates at 2^CNT_W-1.
- Last beat on channel c:
  - The output slot loads the updated values. sum includes data_in, count includes this beat, ovf includes this beat's overflow. out_ch <= c.
  - sum[c], count[c] and ovf[c] clear to 0 on the same edge.
  - Latency: out_valid is high in the cycle after acceptance.
- Channels are independent. Beats on other channels proceed while one channel's result waits, provided in_ready is high.
- in_ch >= NUM_CH (non-power-of-2 NUM_CH only): the beat is accepted, no state changes, and bad_ch pulses high for one cycle after acceptance.
- A last beat on a channel with no prior samples emits sum = data_in and count = 1.
- in_ready low stalls all input, including non-last beats. This keeps the rule single and simple.

Decomposition:
- Package accum_pkg holds:
  - typedef acc_mode_e {ACC_WRAP, ACC_SAT}
  - function acc_add(sum, data, mode), returning the new sum and an overflow bit
  - typedef of the output slot state enum {SLOT_EMPTY, SLOT_FULL}
- Sub-module accum_lane: one channel's sum/count/ovf registers with add, clear and load-enable.
- Top: instantiates NUM_CH lanes via generate, plus channel decode, output slot FSM and handshake logic.

Test Plan:
1. Defaults, channel 0 beats 10, 20, 30(last), out_ready=1 -> out_valid one cycle after the last beat; out_ch=0, sum=60, out_count=3, out_ovf=0; ch0 then cleared (next frame 5(last) gives sum=5, count=1).
2. SUM_W=10, SAT_MODE=0, five beats of 255 on ch1, the 5th last -> sum=251, out_ovf=1. Same with SAT_MODE=1 -> sum=1023, out_ovf=1.
3. Interleaved ch0=1, ch2=100, ch0=2(last), ch2=50(last), out_ready=1 -> two results in order: (ch0, sum 3, count 2), then (ch2, sum 150, count 2).
4. out_ready=0 after a result, then offer further beats -> in_ready=0, result fields stable for 5 cycles. out_ready=1 together with a last beat on another channel -> back-to-back results with no bubble.
5. Mid-frame: ch3 beats 7, 8, then rst for 1 cycle, then ch3 9(last) -> sum=9, count=1, ovf=0; all outputs 0 during and just after reset.
6. NUM_CH=3, beat on in_ch=3 with value 40 -> bad_ch pulses for one cycle; subsequent ch0 frame 4(last) gives sum=4, unaffected.
